// File: rtl/mips_lite_pkg.sv
// Shared constants and types for the mips_lite data-side blocks.
// The store buffer entry pairs an address with its data word.
package mips_lite_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the occupied store buffer entries.
// Later (younger) matches override earlier ones during the scan.
module sb_fwd_match
  import mips_lite_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [PW-1:0]     rd_ptr,
  input  logic [PW:0]       count,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              hit,
  output logic [DATA_W-1:0] fwd_data
);

  logic [PW-1:0] idx;

  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((PW+1)'(i) < count && entries[idx].addr == ld_addr) begin
        hit      = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// FIFO of pending stores in front of the data memory.
// Drains one store per cycle and forwards to same-cycle loads.
module store_buffer
  import mips_lite_pkg::sb_entry_t;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t         entries [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic              rst_q;
  logic              full;
  logic              is_empty;
  logic              blank;
  logic              push;
  logic              drain;
  logic              hit;
  logic [DATA_W-1:0] fwd_data;

  sb_fwd_match #(.DEPTH(DEPTH)) u_match (
    .entries  (entries),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .ld_addr  (ld_addr),
    .hit      (hit),
    .fwd_data (fwd_data)
  );

  // Outputs stay at reset values for the reset cycle and the one after.
  assign blank    = rst | rst_q;
  assign full     = (count == (PW+1)'(DEPTH));
  assign is_empty = (count == '0);
  assign push     = st_valid && !full && !rst;
  assign drain    = !blank && !is_empty && (!ld_req || hit || full);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rst_q  <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      if (push) begin
        entries[wr_ptr] <= '{addr: st_addr, data: st_data};
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (drain)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    st_ready    = blank | !full;
    empty       = blank | is_empty;
    mem_write   = drain;
    mem_addr    = '0;
    mem_data_in = '0;
    ld_valid    = 1'b0;
    ld_data     = '0;
    if (drain) begin
      mem_addr    = entries[rd_ptr].addr;
      mem_data_in = entries[rd_ptr].data;
    end else if (!blank) begin
      mem_addr = ld_addr;
    end
    if (!blank && ld_req) begin
      if (hit) begin
        ld_valid = 1'b1;
        ld_data  = fwd_data;
      end else if (!drain) begin
        ld_valid = 1'b1;
        ld_data  = mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a memory model and
// write/load scoreboards checked by a negedge monitor.
module tb_store_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       st_valid;
  logic [5:0] st_addr;
  logic [7:0] st_data;
  logic       st_ready;
  logic       ld_req;
  logic [5:0] ld_addr;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic [5:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_write;
  logic [7:0] mem_data_out;
  logic       empty;

  logic [7:0]  mem [64];
  logic [13:0] wq [$];
  logic [7:0]  lq [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(6), .DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_ready     (st_ready),
    .ld_req       (ld_req),
    .ld_addr      (ld_addr),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out),
    .empty        (empty)
  );

  assign mem_data_out = mem[mem_addr];

  always @(posedge clk)
    if (mem_write === 1'b1) mem[mem_addr] <= mem_data_in;

  function automatic logic [7:0] init_val(int a);
    return 8'(a) ^ 8'hA5;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one expectation per presented write or load.
  always @(negedge clk) begin
    logic [13:0] w;
    logic [7:0]  l;
    if (mem_write === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got %0h want none",
                 {mem_addr, mem_data_in});
      end else begin
        w = wq.pop_front();
        chk("mem_write", {2'b0, mem_addr, mem_data_in}, {2'b0, w});
      end
    end
    if (ld_valid === 1'b1) begin
      if (lq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load got %0h want none", ld_data);
      end else begin
        l = lq.pop_front();
        chk("ld_data", {8'b0, ld_data}, {8'b0, l});
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic store(logic [5:0] a, logic [7:0] d, bit exp_acc);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    if (exp_acc) wq.push_back({a, d});
  endtask

  initial begin
    rst      = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ld_req   = 1'b0;
    ld_addr  = '0;
    for (int i = 0; i < 64; i++) mem[i] = init_val(i);

    // reset state
    go();
    smp();
    chk("rst_empty", 16'(empty), 16'd1);
    chk("rst_st_ready", 16'(st_ready), 16'd1);
    chk("rst_mem_write", 16'(mem_write), 16'd0);
    go();
    rst = 1'b0;
    ld_req = 1'b1;
    ld_addr = 6'd5;
    smp();
    chk("post_rst_ld_valid", 16'(ld_valid), 16'd0);
    chk("post_rst_mem_addr", 16'(mem_addr), 16'd0);

    // stale entries discarded by reset
    go();
    store(6'd2, 8'd3, 1'b0);
    lq.push_back(init_val(5));
    go();
    store(6'd3, 8'd4, 1'b0);
    lq.push_back(init_val(5));
    go();
    st_valid = 1'b0;
    rst = 1'b1;
    ld_addr = 6'd2;
    smp();
    chk("rst2_ld_valid", 16'(ld_valid), 16'd0);
    chk("rst2_mem_write", 16'(mem_write), 16'd0);
    chk("rst2_empty", 16'(empty), 16'd1);
    chk("rst2_st_ready", 16'(st_ready), 16'd1);
    go();
    rst = 1'b0;
    smp();
    chk("rst2_q_ld_valid", 16'(ld_valid), 16'd0);
    chk("rst2_q_empty", 16'(empty), 16'd1);
    go();
    lq.push_back(init_val(2));
    smp();
    chk("stale_empty", 16'(empty), 16'd1);

    // store then drain
    go();
    ld_req = 1'b0;
    store(6'd10, 8'd30, 1'b1);
    smp();
    chk("sd_no_write", 16'(mem_write), 16'd0);
    go();
    st_valid = 1'b0;
    smp();
    chk("sd_write", 16'(mem_write), 16'd1);
    chk("sd_addr", 16'(mem_addr), 16'd10);
    go();
    smp();
    chk("sd_empty", 16'(empty), 16'd1);

    // forwarding: youngest of two entries to addr 8
    go();
    ld_req = 1'b1;
    ld_addr = 6'd9;
    store(6'd8, 8'd25, 1'b1);
    lq.push_back(init_val(9));
    go();
    store(6'd8, 8'd7, 1'b1);
    lq.push_back(init_val(9));
    go();
    st_valid = 1'b0;
    ld_addr = 6'd8;
    lq.push_back(8'd7);
    go();
    lq.push_back(8'd7);

    // full stall
    go();
    ld_addr = 6'd5;
    store(6'd32, 8'd1, 1'b1);
    lq.push_back(init_val(5));
    go();
    store(6'd48, 8'd49, 1'b1);
    lq.push_back(init_val(5));
    go();
    store(6'd10, 8'd3, 1'b1);
    lq.push_back(init_val(5));
    go();
    store(6'd8, 8'd4, 1'b1);
    lq.push_back(init_val(5));
    go();
    store(6'd60, 8'd60, 1'b0);
    smp();
    chk("full_st_ready", 16'(st_ready), 16'd0);
    chk("full_ld_valid", 16'(ld_valid), 16'd0);
    chk("full_mem_write", 16'(mem_write), 16'd1);
    chk("full_mem_addr", 16'(mem_addr), 16'd32);
    go();
    st_valid = 1'b0;
    lq.push_back(init_val(5));
    smp();
    chk("retry_mem_write", 16'(mem_write), 16'd0);
    go();
    ld_req = 1'b0;
    go();
    go();

    // miss read of data written during the drain
    go();
    ld_req = 1'b1;
    ld_addr = 6'd48;
    lq.push_back(8'd49);
    smp();
    chk("miss_empty", 16'(empty), 16'd1);
    chk("miss_mem_addr", 16'(mem_addr), 16'd48);
    chk("miss_mem_write", 16'(mem_write), 16'd0);

    // back-to-back stream with pointer wrap
    for (int i = 0; i < 10; i++) begin
      go();
      ld_req = 1'b0;
      store(6'(20 + i), 8'(100 + 3 * i), 1'b1);
      smp();
      chk("wrap_st_ready", 16'(st_ready), 16'd1);
    end
    go();
    st_valid = 1'b0;
    go();
    smp();
    chk("wrap_empty", 16'(empty), 16'd1);
    go();
    go();
    smp();

    chk("wq_left", 16'(wq.size()), 16'd0);
    chk("lq_left", 16'(lq.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
